modulo_n_down_counter: RTL
==========================

// Module: modulo_n_down_counter
// PURPOSE
//   Loadable modulo-N down-counter/timer; counterpart of the modulo-N up-counter (counts toward 0).
//   Loaded with a start value, decrements on each enabled cycle, flags expiry at 0.
//   Optionally auto-reloads to N-1 for periodic ticks.
//   Used as programmable delay/timeout generator beside up-counters in sequential datapaths.
// PARAMETERS
//   N      10                       modulus; count range 0..N-1; N >= 1
//   WIDTH  (N>1) ? $clog2(N) : 1    count width; derived, do not override
// PORTS
//   clk          in   1      rising-edge clock, sole clock
//   rst_n        in   1      asynchronous reset, active-low
//   en           in   1      count enable; decrement qualifier in RUN
//   start        in   1      load load_val and enter RUN
//   stop         in   1      abort to IDLE, count frozen
//   auto_reload  in   1      1: wrap 0 -> N-1 and keep running; 0: one-shot
//   load_val     in   WIDTH  start value; values > N-1 clamp to N-1
//   count        out  WIDTH  current count (registered)
//   busy         out  1      1 while in RUN (registered state decode)
//   tc           out  1      combinational: busy && (count == 0)
//   expire       out  1      registered 1-cycle pulse, cycle after terminal decrement
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, count=0, busy=0, expire=0; tc=0.
//   Two states: IDLE, RUN. Per-cycle input priority: stop > start > en.
//   IDLE: count holds; en ignored. start=1 -> count<=clamp(load_val), state<=RUN.
//   RUN, stop=1: state<=IDLE, count holds, no expire.
//   RUN, start=1: restart; count<=clamp(load_val), stay RUN, no expire.
//   RUN, en=0: count holds.
//   RUN, en=1, count>0: count<=count-1.
//   RUN, en=1, count==0 (terminal): expire<=1 next cycle.
//     auto_reload=1: count<=N-1, stay RUN.
//     auto_reload=0: count stays 0, state<=IDLE.
//   auto_reload is sampled only on the terminal cycle; may change freely otherwise.
//   Latency: start at edge k -> busy=1, count=load value after edge k.
//     Load value L with en held 1 -> terminal cycle is the L+1-th enabled cycle;
//     expire high for the cycle after that edge.
//   start with load_val=0: tc=1 immediately; next enabled cycle is terminal.
//   Clamp: load_val >= N loads N-1. Compare at full WIDTH; no truncation wrap.
//   N=1: count is constant 0; every enabled RUN cycle is terminal.
//   Arithmetic: decrement never underflows, guarded by count==0 check. Wrap is explicit N-1.
//   expire: deasserts the following cycle unless another terminal cycle occurs (auto_reload, N=1).
//   Mid-operation reset: async clear to reset values; no pending expire survives.
// STRUCTURE
//   Shared package counter_pkg: state typedef {IDLE, RUN} and a clamp helper (value vs N-1).
//   Single flat module, no sub-module: one state reg, one count reg, one expire reg.
// TESTING  (N=10 unless noted)
//   Reset: assert rst_n=0 mid-RUN, count=5 -> count=0, busy=0, expire=0 asynchronously.
//   One-shot: start, load_val=3, en=1 -> count 3,2,1,0; expire 1 cycle; then busy=0, count=0.
//   Auto-reload: load_val=1, auto_reload=1, en=1 -> count 1,0,9,8; expire once after 0 -> 9.
//   Priority: stop+start same cycle in RUN -> IDLE, count held.
//     start in RUN at count=4, load_val=7 -> count=7, no expire.
//   Clamp and gate: load_val=15 -> count=9; en=0 for 5 cycles -> count stays 9.
//   N=1 build: start, en=1 -> expire every cycle with auto_reload=1; count always 0.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and clamp helper for the modulo-N counters
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Saturate a start value to the top of the count range; full-width compare, no wrap.
    function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] top);
        return (val > top) ? top : val;
    endfunction

endpackage

// File: rtl/modulo_n_down_counter.sv
// rtl/modulo_n_down_counter.sv - loadable modulo-N down-counter/timer with expiry pulse and auto-reload
module modulo_n_down_counter
    import counter_pkg::*;
#(
    parameter int N     = 10,
    parameter int WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             expire
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp(32'(load_val), 32'(N - 1)));

    assign busy = (state == RUN);
    assign tc   = busy && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stop && start) begin
                        count <= load_clamped;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        count <= load_clamped;
                    end else if (en) begin
                        // Terminal cycle: the zero check also guards the decrement against underflow.
                        if (count == '0) begin
                            expire <= 1'b1;
                            if (auto_reload) begin
                                count <= TOP;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
